// File: rtl/reg_bank_scan.sv
// Register file with two combinational read ports and a view mode that
// pages register pairs (2k, 2k+1) onto R/S under control of a step input.
module reg_bank_scan #(
  parameter int DW      = 16,
  parameter int AW      = 3,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] w_adr,
  input  logic [DW-1:0] w_data,
  input  logic [AW-1:0] r_adr,
  input  logic [AW-1:0] s_adr,
  input  logic          view_mode,
  input  logic          step,
  output logic [DW-1:0] R,
  output logic [DW-1:0] S,
  output logic [AW-2:0] view_ptr
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] regs_q [NREG];
  logic [AW-2:0] view_ptr_q, view_ptr_d;
  logic          step_q;
  logic          wr_en;
  logic [AW-1:0] ra, sa;

  // Writes to a hardwired-zero register 0 are dropped entirely.
  assign wr_en = we && !((R0_ZERO != 0) && (w_adr == '0));

  always_comb begin
    view_ptr_d = view_ptr_q;
    if (view_mode && step && !step_q) begin
      view_ptr_d = view_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      view_ptr_q <= '0;
      step_q     <= 1'b0;
    end else begin
      step_q     <= step;
      view_ptr_q <= view_ptr_d;
      if (wr_en) begin
        regs_q[w_adr] <= w_data;
      end
    end
  end

  always_comb begin
    ra = r_adr;
    sa = s_adr;
    if (view_mode) begin
      ra = {view_ptr_q, 1'b0};
      sa = {view_ptr_q, 1'b1};
    end
  end

  function automatic logic [DW-1:0] read_port(input logic [AW-1:0] adr);
    logic [DW-1:0] val;
    val = regs_q[adr];
    if ((BYPASS != 0) && wr_en && (w_adr == adr)) begin
      val = w_data;
    end
    if ((R0_ZERO != 0) && (adr == '0)) begin
      val = '0;
    end
    return val;
  endfunction

  assign R        = read_port(ra);
  assign S        = read_port(sa);
  assign view_ptr = view_ptr_q;

endmodule

// File: tb/tb_reg_bank_scan.sv
// Bench for reg_bank_scan: two instances (forwarding/ordinary r0 and
// no-forwarding/hardwired r0) checked against a behavioural model each cycle.
module tb_reg_bank_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  w_adr = '0;
  logic [15:0] w_data = '0;
  logic [2:0]  r_adr = '0;
  logic [2:0]  s_adr = '0;
  logic        view_mode = 1'b0;
  logic        step = 1'b0;

  logic [15:0] ra_out, sa_out, rb_out, sb_out;
  logic [1:0]  pa_out, pb_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_scan #(.DW(16), .AW(3), .BYPASS(1), .R0_ZERO(0)) dut_a (
    .clk(clk), .reset(reset), .we(we), .w_adr(w_adr), .w_data(w_data),
    .r_adr(r_adr), .s_adr(s_adr), .view_mode(view_mode), .step(step),
    .R(ra_out), .S(sa_out), .view_ptr(pa_out)
  );

  reg_bank_scan #(.DW(16), .AW(3), .BYPASS(0), .R0_ZERO(1)) dut_b (
    .clk(clk), .reset(reset), .we(we), .w_adr(w_adr), .w_data(w_data),
    .r_adr(r_adr), .s_adr(s_adr), .view_mode(view_mode), .step(step),
    .R(rb_out), .S(sb_out), .view_ptr(pb_out)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: contents of each bank, current pair index, last step level.
  int  mem_a [8];
  int  mem_b [8];
  int  pair_k = 0;
  bit  prev_step = 0;
  bit  started = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] = 0;
        mem_b[i] = 0;
      end
      pair_k    = 0;
      prev_step = 0;
      started   = 1;
    end else begin
      if (we) begin
        mem_a[w_adr] = w_data;
        if (w_adr != 0) mem_b[w_adr] = w_data;
      end
      if (view_mode && step && !prev_step) pair_k = (pair_k + 1) % 4;
      prev_step = step;
    end
  end

  function automatic int exp_a(input int adr);
    if (we && w_adr == adr) return w_data;
    return mem_a[adr];
  endfunction

  function automatic int exp_b(input int adr);
    if (adr == 0) return 0;
    return mem_b[adr];
  endfunction

  always @(negedge clk) begin
    int ra, sa;
    if (started) begin
      ra = view_mode ? 2 * pair_k     : int'(r_adr);
      sa = view_mode ? 2 * pair_k + 1 : int'(s_adr);
      check("model_R_a", ra_out, exp_a(ra));
      check("model_S_a", sa_out, exp_a(sa));
      check("model_R_b", rb_out, exp_b(ra));
      check("model_S_b", sb_out, exp_b(sa));
      check("model_ptr_a", pa_out, pair_k);
      check("model_ptr_b", pb_out, pair_k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_R", ra_out, 0);
    check("rst_S", sa_out, 0);
    check("rst_ptr", pa_out, 0);
    tick();

    for (int i = 0; i < 8; i++) begin
      we = 1'b1; w_adr = 3'(i); w_data = 16'(16'h1111 * i);
      tick();
    end
    we = 1'b0;

    r_adr = 3'd3; s_adr = 3'd5;
    @(negedge clk);
    check("rd_R_a", ra_out, 16'h3333);
    check("rd_S_a", sa_out, 16'h5555);
    check("rd_S_b", sb_out, 16'h5555);
    tick();

    we = 1'b1; w_adr = 3'd2; w_data = 16'hBEEF; r_adr = 3'd2;
    @(negedge clk);
    check("byp_R_a", ra_out, 16'hBEEF);
    check("nobyp_R_b", rb_out, 16'h2222);
    tick();
    we = 1'b0;
    @(negedge clk);
    check("nobyp_next_R_b", rb_out, 16'hBEEF);
    tick();
    we = 1'b1; w_data = 16'h2222;
    tick();
    we = 1'b0;

    view_mode = 1'b1;
    @(negedge clk);
    check("view0_R", ra_out, 16'h0000);
    check("view0_S", sa_out, 16'h1111);
    tick();
    for (int p = 1; p <= 4; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
      @(negedge clk);
      check("view_R", ra_out, 16'(16'h2222 * (p % 4)));
      check("view_S", sa_out, 16'(16'h2222 * (p % 4) + 16'h1111));
      tick();
    end

    step = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("held_ptr", pa_out, 1);
    step = 1'b0;
    tick();

    view_mode = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    @(negedge clk);
    check("normal_step_ptr", pa_out, 1);
    tick();

    view_mode = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    @(negedge clk);
    check("pre_rst_ptr", pa_out, 2);
    check("pre_rst_R", ra_out, 16'h4444);
    tick();
    reset = 1'b1; step = 1'b1; we = 1'b1; w_adr = 3'd4; w_data = 16'hABCD;
    tick();
    reset = 1'b0; step = 1'b0; we = 1'b0;
    @(negedge clk);
    check("mid_rst_ptr", pa_out, 0);
    check("mid_rst_R", ra_out, 0);
    check("mid_rst_S", sa_out, 0);
    tick();
    view_mode = 1'b0; r_adr = 3'd4; s_adr = 3'd7;
    @(negedge clk);
    check("mid_rst_reg4", ra_out, 0);
    check("mid_rst_reg7", sa_out, 0);
    tick();

    we = 1'b1; w_adr = 3'd0; w_data = 16'hFFFF; r_adr = 3'd0;
    @(negedge clk);
    check("r0_byp_b", rb_out, 0);
    check("r0_byp_a", ra_out, 16'hFFFF);
    tick();
    we = 1'b0;
    @(negedge clk);
    check("r0_after_b", rb_out, 0);
    check("r0_after_a", ra_out, 16'hFFFF);
    tick();

    view_mode = 1'b1;
    step = 1'b1; we = 1'b1; w_adr = 3'd2; w_data = 16'h1234;
    tick();
    step = 1'b0; we = 1'b0;
    @(negedge clk);
    check("step_wr_R", ra_out, 16'h1234);
    check("step_wr_S", sa_out, 0);
    check("step_wr_ptr", pb_out, 1);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
